bsg_link_delay_train: RTL and testbench

- Receive-side training FSM that sits directly downstream of the per-bit link delay line.
- Samples the delayed channel bits (valid, clk-forward copy and 16 data bits) while the far end transmits PRBS7 on every bit.
- Sweeps all four delay taps and scores each bit per tap, then drives each bit's 2-bit mux select to the centre of its passing window.
- Replaces manual tag-programmed delay selects once training has completed.

---
 rtl/bsg_link_delay_train_pkg.sv | 47 ++++
 rtl/bsg_link_delay_train_bit_checker.sv | 47 ++++
 rtl/bsg_link_delay_train.sv | 157 +++++++++++++++
 tb/tb_bsg_link_delay_train.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_link_delay_train_pkg.sv
// Shared constants, FSM state encoding and the window-pick lookup for
// the link delay training block.
package bsg_link_delay_train_pkg;

  localparam int unsigned delay_taps_gp    = 4;
  localparam int unsigned tap_sel_width_gp = 2;

  // PRBS7 recurrence: d[n] = d[n-7] ^ d[n-6]
  localparam int unsigned prbs_tap_a_gp = 7;
  localparam int unsigned prbs_tap_b_gp = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_RECORD,
    S_DECIDE,
    S_DONE
  } state_e;

  // Maps a 4-bit per-tap pass mask to {fail, sel[1:0]}: centre of the
  // longest contiguous passing run, lowest start on ties.
  function automatic logic [2:0] window_pick(input logic [3:0] mask);
    logic [2:0] r;
    case (mask)
      4'b0000: r = 3'b1_00;
      4'b0001: r = 3'b0_00;
      4'b0010: r = 3'b0_01;
      4'b0011: r = 3'b0_00;
      4'b0100: r = 3'b0_10;
      4'b0101: r = 3'b0_00;
      4'b0110: r = 3'b0_01;
      4'b0111: r = 3'b0_01;
      4'b1000: r = 3'b0_11;
      4'b1001: r = 3'b0_00;
      4'b1010: r = 3'b0_01;
      4'b1011: r = 3'b0_00;
      4'b1100: r = 3'b0_10;
      4'b1101: r = 3'b0_10;
      4'b1110: r = 3'b0_10;
      4'b1111: r = 3'b0_01;
      default: r = 3'b1_00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bsg_link_delay_train_bit_checker.sv
// Per-bit PRBS7 checker: history shift register, toggle detector and
// sticky error flag. A bit that never toggles in the window counts as failed.
module bsg_link_delay_train_bit_checker
  import bsg_link_delay_train_pkg::*;
(
  input  logic clk_i,
  input  logic async_reset_n_i,
  input  logic sample_i,
  input  logic check_en_i,
  input  logic clear_i,
  output logic err_o
);

  logic [6:0] hist_q, hist_d;
  logic       err_q, err_d;
  logic       tog_q, tog_d;

  // Next-state: history always shifts; flags accumulate only while checking
  always_comb begin
    hist_d = {hist_q[5:0], sample_i};
    err_d  = err_q;
    tog_d  = tog_q;
    if (clear_i) begin
      err_d = 1'b0;
      tog_d = 1'b0;
    end else if (check_en_i) begin
      err_d = err_q | (sample_i != (hist_q[prbs_tap_a_gp-1] ^ hist_q[prbs_tap_b_gp-1]));
      tog_d = tog_q | (sample_i != hist_q[0]);
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      hist_q <= '0;
      err_q  <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      err_q  <= err_d;
      tog_q  <= tog_d;
    end
  end

  assign err_o = err_q | ~tog_q;

endmodule

// File: rtl/bsg_link_delay_train.sv
// Receive-side delay-line training: sweeps all taps, scores every bit on
// PRBS7 per tap, then selects the centre of each bit's passing window.
module bsg_link_delay_train
  import bsg_link_delay_train_pkg::*;
#(
  parameter int unsigned width_p         = 18,
  parameter int unsigned settle_cycles_p = 16,
  parameter int unsigned check_cycles_p  = 256
) (
  input  logic                   clk_i,
  input  logic                   async_reset_n_i,
  input  logic                   start_i,
  input  logic [width_p-1:0]     data_i,
  output logic [2*width_p-1:0]   sel_o,
  output logic [4*width_p-1:0]   pass_mask_o,
  output logic [width_p-1:0]     fail_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned max_cyc_lp = (settle_cycles_p > check_cycles_p) ? settle_cycles_p : check_cycles_p;
  localparam int unsigned cnt_w_lp   = $clog2(max_cyc_lp) + 1;

  state_e                  state_q, state_d;
  logic [1:0]              tap_q, tap_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [2*width_p-1:0]    sel_q, sel_d;
  logic [4*width_p-1:0]    mask_q, mask_d;
  logic [width_p-1:0]      fail_q, fail_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [width_p-1:0]      data_q;
  logic [width_p-1:0]      err;
  logic                    check_en;
  logic                    clear;

  assign check_en = (state_q == S_CHECK);
  assign clear    = (state_q != S_CHECK);

  // Entry flop isolating the delay line outputs
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) data_q <= '0;
    else                  data_q <= data_i;
  end

  for (genvar k = 0; k < width_p; k++) begin : g_chk
    bsg_link_delay_train_bit_checker u_chk (
      .clk_i           (clk_i),
      .async_reset_n_i (async_reset_n_i),
      .sample_i        (data_q[k]),
      .check_en_i      (check_en),
      .clear_i         (clear),
      .err_o           (err[k])
    );
  end

  // Next-state and output-register logic for the training sequence
  always_comb begin
    logic [3:0] nib;
    logic [2:0] pick;
    state_d = state_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = done_q;
    nib     = '0;
    pick    = '0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_SETTLE;
          tap_d   = '0;
          cnt_d   = '0;
          sel_d   = '0;
          mask_d  = '0;
          fail_d  = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == cnt_w_lp'(settle_cycles_p - 1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (cnt_q == cnt_w_lp'(check_cycles_p - 1)) begin
          cnt_d   = '0;
          state_d = S_RECORD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RECORD: begin
        for (int unsigned k = 0; k < width_p; k++) begin
          nib         = mask_q[k*4 +: 4];
          nib[tap_q]  = ~err[k];
          mask_d[k*4 +: 4] = nib;
        end
        if (tap_q != 2'd3) begin
          tap_d   = tap_q + 2'd1;
          sel_d   = {width_p{tap_q + 2'd1}};
          state_d = S_SETTLE;
        end else begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        for (int unsigned k = 0; k < width_p; k++) begin
          pick             = window_pick(mask_q[k*4 +: 4]);
          sel_d[k*2 +: 2]  = pick[1:0];
          fail_d[k]        = pick[2];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and result registers
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel_o       = sel_q;
  assign pass_mask_o = mask_q;
  assign fail_o      = fail_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_bsg_link_delay_train.sv
// Directed bench: models a per-bit delay line feeding PRBS7 with per-tap
// error injection, and checks training results against hand-computed values.
module tb_bsg_link_delay_train;

  localparam int W = 18;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [W-1:0]     data_i;
  logic [2*W-1:0]   sel_o;
  logic [4*W-1:0]   pass_mask_o;
  logic [W-1:0]     fail_o;
  logic             busy_o;
  logic             done_o;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_link_delay_train #(
    .width_p         (W),
    .settle_cycles_p (16),
    .check_cycles_p  (256)
  ) dut (
    .clk_i           (clk),
    .async_reset_n_i (rst_n),
    .start_i         (start_i),
    .data_i          (data_i),
    .sel_o           (sel_o),
    .pass_mask_o     (pass_mask_o),
    .fail_o          (fail_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Delay-line model configuration: taps at which a bit sees errors, or stuck value
  logic [3:0] bad_cfg   [W];
  logic       stuck_cfg [W];
  logic       stuckv_cfg[W];

  // PRBS7 source per bit, corrupted every 5th cycle at that bit's bad taps
  initial begin
    logic [6:0] gen [W];
    logic [W-1:0] d;
    logic nb;
    logic [1:0] tap;
    int unsigned cyc;
    cyc = 0;
    for (int k = 0; k < W; k++) gen[k] = 7'(k + 1);
    data_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < W; k++) begin
        nb     = gen[k][6] ^ gen[k][5];
        gen[k] = {gen[k][5:0], nb};
        tap    = sel_o[2*k +: 2];
        if (stuck_cfg[k]) d[k] = stuckv_cfg[k];
        else              d[k] = nb ^ (bad_cfg[k][tap] && (cyc % 5 == 0));
      end
      data_i = d;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clean_cfg();
    for (int k = 0; k < W; k++) begin
      bad_cfg[k]    = 4'b0000;
      stuck_cfg[k]  = 1'b0;
      stuckv_cfg[k] = 1'b0;
    end
  endtask

  // Pulse start, then wait (bounded) for done; lat counts the start edge as 1
  task automatic run(input int restart_at, output int lat);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    chk("busy_after_start", 128'(busy_o), 128'(1));
    chk("done_clear_after_start", 128'(done_o), 128'(0));
    while (!done_o && lat < 3000) begin
      start_i = (lat == restart_at);
      @(posedge clk); #1;
      lat++;
      if (restart_at != 0 && lat == restart_at + 1) begin
        chk("busy_midrun", 128'(busy_o), 128'(1));
        chk("done_low_midrun", 128'(done_o), 128'(0));
      end
    end
    start_i = 1'b0;
    chk("done_reached", 128'(done_o), 128'(1));
    chk("latency", 128'(lat), 128'(1094));
    chk("busy_after_done", 128'(busy_o), 128'(0));
  endtask

  task automatic chk_all_clean(input string tag);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("%s_mask[%0d]", tag, k), 128'(pass_mask_o[4*k +: 4]), 128'(4'b1111));
      chk($sformatf("%s_sel[%0d]", tag, k), 128'(sel_o[2*k +: 2]), 128'(2'd1));
    end
    chk($sformatf("%s_fail", tag), 128'(fail_o), 128'(0));
  endtask

  typedef struct {
    int         bit_idx;
    logic [3:0] bad_taps;
    logic       stuck;
    logic       stuck_val;
    logic [3:0] exp_mask;
    logic [1:0] exp_sel;
    logic       exp_fail;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    logic [3:0] exp_mask [W];
    logic [1:0] exp_sel  [W];
    logic       exp_fail [W];

    //            bit bad     stk sv  mask     sel fail
    vecs[0]  = '{0,  4'b0010, 0, 0, 4'b1101, 2'd2, 0};
    vecs[1]  = '{1,  4'b1010, 0, 0, 4'b0101, 2'd0, 0};
    vecs[2]  = '{2,  4'b0000, 0, 0, 4'b1111, 2'd1, 0};
    vecs[3]  = '{3,  4'b0000, 1, 1, 4'b0000, 2'd0, 1};
    vecs[4]  = '{5,  4'b1001, 0, 0, 4'b0110, 2'd1, 0};
    vecs[5]  = '{7,  4'b0101, 0, 0, 4'b1010, 2'd1, 0};
    vecs[6]  = '{9,  4'b0011, 0, 0, 4'b1100, 2'd2, 0};
    vecs[7]  = '{12, 4'b1110, 0, 0, 4'b0001, 2'd0, 0};
    vecs[8]  = '{14, 4'b0001, 0, 0, 4'b1110, 2'd2, 0};
    vecs[9]  = '{16, 4'b0111, 0, 0, 4'b1000, 2'd3, 0};
    vecs[10] = '{17, 4'b0000, 1, 0, 4'b0000, 2'd0, 1};

    clean_cfg();
    start_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst_sel", 128'(sel_o), 128'(0));
    chk("rst_mask", 128'(pass_mask_o), 128'(0));
    chk("rst_fail", 128'(fail_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean PRBS on every bit
    run(0, lat);
    chk_all_clean("clean");

    // Per-bit fault table, with an ignored start pulse at cycle 500
    for (int k = 0; k < W; k++) begin
      exp_mask[k] = 4'b1111;
      exp_sel[k]  = 2'd1;
      exp_fail[k] = 1'b0;
    end
    foreach (vecs[i]) begin
      bad_cfg[vecs[i].bit_idx]    = vecs[i].bad_taps;
      stuck_cfg[vecs[i].bit_idx]  = vecs[i].stuck;
      stuckv_cfg[vecs[i].bit_idx] = vecs[i].stuck_val;
      exp_mask[vecs[i].bit_idx]   = vecs[i].exp_mask;
      exp_sel[vecs[i].bit_idx]    = vecs[i].exp_sel;
      exp_fail[vecs[i].bit_idx]   = vecs[i].exp_fail;
    end
    run(500, lat);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("tbl_mask[%0d]", k), 128'(pass_mask_o[4*k +: 4]), 128'(exp_mask[k]));
      chk($sformatf("tbl_sel[%0d]", k), 128'(sel_o[2*k +: 2]), 128'(exp_sel[k]));
      chk($sformatf("tbl_fail[%0d]", k), 128'(fail_o[k]), 128'(exp_fail[k]));
    end

    // Results hold in DONE
    repeat (20) @(posedge clk);
    #1;
    chk("hold_mask5", 128'(pass_mask_o[4*5 +: 4]), 128'(4'b0110));
    chk("hold_fail", 128'(fail_o), 128'((W'(1) << 3) | (W'(1) << 17)));
    chk("hold_done", 128'(done_o), 128'(1));

    // Restart from DONE: outputs clear and busy rises next cycle
    clean_cfg();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("restart_sel", 128'(sel_o), 128'(0));
    chk("restart_mask", 128'(pass_mask_o), 128'(0));
    chk("restart_fail", 128'(fail_o), 128'(0));
    chk("restart_done", 128'(done_o), 128'(0));
    chk("restart_busy", 128'(busy_o), 128'(1));

    // Run into CHECK of tap 2, then reset asynchronously between edges
    repeat (2*273 + 16 + 50) @(posedge clk);
    #1;
    chk("pre_reset_sel_tap2", 128'(sel_o[1:0]), 128'(2'd2));
    chk("pre_reset_mask0", 128'(pass_mask_o[3:0]), 128'(4'b0011));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 128'(sel_o), 128'(0));
    chk("async_rst_mask", 128'(pass_mask_o), 128'(0));
    chk("async_rst_fail", 128'(fail_o), 128'(0));
    chk("async_rst_busy", 128'(busy_o), 128'(0));
    chk("async_rst_done", 128'(done_o), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh full run after reset
    run(0, lat);
    chk_all_clean("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
